activity_hold: RTL



---
 rtl/activity_hold_if.sv | 25 ++
 rtl/activity_hold.sv | 128 ++++++++++++
 2 files changed

// File: rtl/activity_hold_if.sv
// Strobe inputs and LED outputs shared between the activity scheduler and the
// block that feeds it strobes and consumes its LED vectors.
interface activity_hold_if;
  logic [15:0] in_strobe;
  logic [15:0] out_strobe;
  logic        lamp_test;
  logic [15:0] led_in;
  logic [15:0] led_out;

  modport master (
    output in_strobe,
    output out_strobe,
    output lamp_test,
    input  led_in,
    input  led_out
  );

  modport slave (
    input  in_strobe,
    input  out_strobe,
    input  lamp_test,
    output led_in,
    output led_out
  );
endinterface

// File: rtl/activity_hold.sv
// Stretches per-port MIDI byte strobes into visible LED on-times, with a forced
// off-gap so continuous traffic blinks. 32 channels share one tick prescaler.
module activity_hold #(
  parameter int TICK_DIV   = 16,
  parameter int HOLD_TICKS = 6,
  parameter int GAP_TICKS  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  activity_hold_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } chan_state_e;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_TICKS);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_TICKS);

  logic [TICK_DIV-1:0] presc_q;
  logic                tick;
  logic [31:0]         strobe;
  chan_state_e         state_q [32];
  chan_state_e         state_d [32];
  logic [7:0]          cnt_q [32];
  logic [7:0]          cnt_d [32];
  logic [31:0]         pend_q;
  logic [31:0]         pend_d;
  logic [31:0]         on_d;
  logic [15:0]         led_in_q;
  logic [15:0]         led_out_q;

  assign strobe = {bus.out_strobe, bus.in_strobe};
  assign tick   = &presc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pend_q <= pend_d;
    end
  end

  // A strobe seen while ON or GAP is remembered in pend and honoured when the
  // gap expires, so back-to-back traffic never loses a re-trigger.
  always_comb begin
    pend_d = pend_q;
    on_d   = '0;
    for (int i = 0; i < 32; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (strobe[i]) begin
            state_d[i] = ON;
            cnt_d[i]   = HOLD_LOAD;
            pend_d[i]  = 1'b0;
          end
        end
        ON: begin
          if (strobe[i]) pend_d[i] = 1'b1;
          if (tick) begin
            if (cnt_q[i] == 8'd1) begin
              state_d[i] = GAP;
              cnt_d[i]   = GAP_LOAD;
            end else begin
              cnt_d[i] = cnt_q[i] - 8'd1;
            end
          end
        end
        GAP: begin
          if (strobe[i]) pend_d[i] = 1'b1;
          if (tick) begin
            if (cnt_q[i] == 8'd1) begin
              if (pend_q[i] || strobe[i]) begin
                state_d[i] = ON;
                cnt_d[i]   = HOLD_LOAD;
                pend_d[i]  = 1'b0;
              end else begin
                state_d[i] = IDLE;
              end
            end else begin
              cnt_d[i] = cnt_q[i] - 8'd1;
            end
          end
        end
        default: begin
          state_d[i] = IDLE;
        end
      endcase
      on_d[i] = (state_d[i] == ON);
    end
  end

  // LEDs register the next-state view so a strobe lights its LED right after
  // the edge that samples it; lamp test only overrides the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_in_q  <= '0;
      led_out_q <= '0;
    end else begin
      led_in_q  <= on_d[15:0]  | {16{bus.lamp_test}};
      led_out_q <= on_d[31:16] | {16{bus.lamp_test}};
    end
  end

  assign bus.led_in  = led_in_q;
  assign bus.led_out = led_out_q;

endmodule
